nn_ram_arbiter: RTL and testbench

Single-port RAM arbiter for the nnRv SoC. It shares the 2048-word program/data RAM between three requesters: the CPU data port (load/store), the CPU instruction-fetch port, and the video DMA port that feeds the VGA coordinate path. Arbitration is rotating-priority, one beat per cycle. The video port may hold the RAM for a self-addressed burst. The block sits between the core/DMA and the RAM macro, and owns all RAM enables.

---
 rtl/nn_mem_pkg.sv | 27 ++
 rtl/nn_rr_pick.sv | 30 +++
 rtl/nn_ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_nn_ram_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// Shared definitions for the nnRv RAM arbitration path: requester indices,
// arbiter state encoding and the video burst-length clamp.
package nn_mem_pkg;

   localparam int REQ_DATA      = 0;
   localparam int REQ_FETCH     = 1;
   localparam int REQ_VIDEO     = 2;
   localparam int MAX_BURST_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // A zero length still moves one beat; oversize requests are clipped.
   function automatic logic [3:0] eff_len(input logic [3:0] blen, input logic [3:0] max_b);
      logic [3:0] len;
      if (blen == 4'd0)
         len = 4'd1;
      else if (blen > max_b)
         len = max_b;
      else
         len = blen;
      return len;
   endfunction

endpackage

// File: rtl/nn_rr_pick.sv
// 3-way rotating-priority picker: the search starts at (last+1) mod 3 and
// returns a one-hot grant for the first active request found.
module nn_rr_pick (
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] gnt
);

   always_comb begin
      gnt = 3'b000;
      case (last)
         2'd0: begin
            if (req[1])      gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
         end
         2'd1: begin
            if (req[2])      gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
         end
         default: begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/nn_ram_arbiter.sv
// Single-port RAM arbiter for data, fetch and video requesters with
// rotating priority and self-addressed video bursts.
module nn_ram_arbiter
   import nn_mem_pkg::*;
#(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [2:0]            REQ,
   input  logic [2:0]            WE,
   input  logic [3*ADDR_W-1:0]   ADDR,
   input  logic [3*DATA_W-1:0]   WDATA,
   input  logic [3:0]            BLEN,
   output logic [2:0]            GNT,
   output logic [2:0]            RVALID,
   output logic [DATA_W-1:0]     RDATA,
   output logic                  RAM_EN,
   output logic                  RAM_WE,
   output logic [ADDR_W-1:0]     RAM_ADDR,
   output logic [DATA_W-1:0]     RAM_WDATA,
   input  logic [DATA_W-1:0]     RAM_RDATA,
   output logic                  BUSY
);

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   arb_state_e          state_reg, state_next;
   logic [1:0]          last_reg, last_next;
   logic [3:0]          remaining_reg, remaining_next;
   logic [ADDR_W-1:0]   baddr_reg, baddr_next;
   logic                bwe_reg, bwe_next;
   logic [2:0]          rvalid_reg, rvalid_next;

   logic [ADDR_W-1:0]   addr_s  [3];
   logic [DATA_W-1:0]   wdata_s [3];

   logic [2:0]          pick_req, pick_gnt, gnt_int;
   logic [1:0]          pick_last, gnt_idx;
   logic                gnt_any, burst_beat;
   logic [3:0]          vid_len;
   logic [ADDR_W-1:0]   ram_addr_c;
   logic [DATA_W-1:0]   ram_wdata_c;
   logic                ram_we_c;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slice
         assign addr_s[gi]  = ADDR[gi*ADDR_W +: ADDR_W];
         assign wdata_s[gi] = WDATA[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // During a burst only video may win; an abort re-arbitrates with video masked.
   assign burst_beat = (state_reg == BURST) && REQ[REQ_VIDEO];
   assign pick_req   = (state_reg == BURST) ? (REQ & 3'b011) : REQ;
   assign pick_last  = (state_reg == BURST) ? 2'(REQ_VIDEO) : last_reg;

   nn_rr_pick u_pick (
      .req  (pick_req),
      .last (pick_last),
      .gnt  (pick_gnt)
   );

   assign gnt_int = burst_beat ? 3'b100 : pick_gnt;
   assign gnt_any = |gnt_int;
   assign vid_len = eff_len(BLEN, MAX_B);

   always_comb begin
      case (gnt_int)
         3'b010:  gnt_idx = 2'(REQ_FETCH);
         3'b100:  gnt_idx = 2'(REQ_VIDEO);
         default: gnt_idx = 2'(REQ_DATA);
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= IDLE;
         last_reg      <= 2'(REQ_VIDEO);
         remaining_reg <= 4'd0;
         baddr_reg     <= '0;
         bwe_reg       <= 1'b0;
         rvalid_reg    <= 3'b000;
      end else begin
         state_reg     <= state_next;
         last_reg      <= last_next;
         remaining_reg <= remaining_next;
         baddr_reg     <= baddr_next;
         bwe_reg       <= bwe_next;
         rvalid_reg    <= rvalid_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next     = state_reg;
      last_next      = last_reg;
      remaining_next = remaining_reg;
      baddr_next     = baddr_reg;
      bwe_next       = bwe_reg;
      case (state_reg)
         IDLE: begin
            if (gnt_any)
               last_next = gnt_idx;
            if (gnt_int[REQ_VIDEO] && (vid_len > 4'd1)) begin
               state_next     = BURST;
               remaining_next = vid_len - 4'd1;
               baddr_next     = addr_s[REQ_VIDEO] + 1'b1;
               bwe_next       = WE[REQ_VIDEO];
            end
         end
         BURST: begin
            if (REQ[REQ_VIDEO]) begin
               baddr_next     = baddr_reg + 1'b1;
               remaining_next = remaining_reg - 4'd1;
               if (remaining_reg == 4'd1) begin
                  state_next = IDLE;
                  last_next  = 2'(REQ_VIDEO);
               end
            end else begin
               state_next     = IDLE;
               remaining_next = 4'd0;
               last_next      = gnt_any ? gnt_idx : 2'(REQ_VIDEO);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ram_addr_c  = '0;
      ram_we_c    = 1'b0;
      ram_wdata_c = '0;
      if (burst_beat) begin
         ram_addr_c  = baddr_reg;
         ram_we_c    = bwe_reg;
         ram_wdata_c = wdata_s[REQ_VIDEO];
      end else begin
         case (gnt_int)
            3'b001: begin
               ram_addr_c  = addr_s[REQ_DATA];
               ram_we_c    = WE[REQ_DATA];
               ram_wdata_c = wdata_s[REQ_DATA];
            end
            3'b010: begin
               ram_addr_c  = addr_s[REQ_FETCH];
               ram_we_c    = WE[REQ_FETCH];
               ram_wdata_c = wdata_s[REQ_FETCH];
            end
            3'b100: begin
               ram_addr_c  = addr_s[REQ_VIDEO];
               ram_we_c    = WE[REQ_VIDEO];
               ram_wdata_c = wdata_s[REQ_VIDEO];
            end
            default: ;
         endcase
      end
      rvalid_next = (gnt_any && !ram_we_c) ? gnt_int : 3'b000;
   end

   assign GNT       = gnt_int & {3{~RST}};
   assign RAM_EN    = gnt_any & ~RST;
   assign RAM_WE    = gnt_any & ram_we_c & ~RST;
   assign RAM_ADDR  = ram_addr_c;
   assign RAM_WDATA = ram_wdata_c;
   assign RVALID    = rvalid_reg & {3{~RST}};
   assign RDATA     = RAM_RDATA;
   assign BUSY      = (state_reg == BURST) & ~RST;

endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Directed bench for nn_ram_arbiter with a behavioural synchronous RAM.
module tb_nn_ram_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;

   logic            CLK = 1'b0;
   logic            RST;
   logic [2:0]      REQ, WE;
   logic [3*AW-1:0] ADDR;
   logic [3*DW-1:0] WDATA;
   logic [3:0]      BLEN;
   logic [2:0]      GNT, RVALID;
   logic [DW-1:0]   RDATA, RAM_WDATA, RAM_RDATA;
   logic            RAM_EN, RAM_WE, BUSY;
   logic [AW-1:0]   RAM_ADDR;

   logic [DW-1:0]   mem [2048];

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   nn_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(8)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
      .BLEN(BLEN), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .RAM_EN(RAM_EN),
      .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
      .RAM_RDATA(RAM_RDATA), .BUSY(BUSY)
   );

   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
         else        RAM_RDATA     <= mem[RAM_ADDR];
      end
   end

   function automatic logic [31:0] memval(input logic [AW-1:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_port(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      ADDR[i*AW +: AW]  = a;
      WE[i]             = w;
      WDATA[i*DW +: DW] = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      $display("check %-12s observed=%h expected=%h", tag, obs, exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [2:0]    eg;
      for (int i = 0; i < 2048; i++) mem[i] = memval(AW'(i));
      RAM_RDATA = '0;
      RST = 1'b1; REQ = 3'b000; WE = 3'b000; ADDR = '0; WDATA = '0; BLEN = 4'd1;
      tick(); tick();

      // Reset: outputs held low even with every requester active
      REQ = 3'b111; #1;
      chk("rst_gnt",    32'(GNT),    32'h0);
      chk("rst_ram_en", 32'(RAM_EN), 32'h0);
      chk("rst_busy",   32'(BUSY),   32'h0);
      chk("rst_rvalid", 32'(RVALID), 32'h0);

      // Round robin, all reads
      set_port(0, 11'h005, 1'b0, '0);
      set_port(1, 11'h006, 1'b0, '0);
      set_port(2, 11'h007, 1'b0, '0);
      BLEN = 4'd1;
      RST = 1'b0; #1;
      for (int i = 0; i < 6; i++) begin
         eg = 3'b001 << (i % 3);
         a  = 11'h005 + AW'(i % 3);
         chk("rr_gnt",  32'(GNT),      32'(eg));
         chk("rr_addr", 32'(RAM_ADDR), 32'(a));
         tick();
         chk("rr_rvalid", 32'(RVALID), 32'(eg));
         chk("rr_rdata",  RDATA,       memval(a));
      end
      REQ = 3'b000; tick();

      // Lone fetch read so that video is next in rotation
      REQ = 3'b010; set_port(1, 11'h020, 1'b0, '0); #1;
      chk("f_gnt", 32'(GNT), 32'h2);
      tick();
      chk("f_rvalid", 32'(RVALID), 32'h2);
      chk("f_rdata",  RDATA,       memval(11'h020));

      // Video burst of 4 wrapping past the top, data waiting throughout
      REQ = 3'b101; BLEN = 4'd4;
      set_port(2, 11'h7FE, 1'b0, '0);
      set_port(0, 11'h030, 1'b0, '0);
      #1;
      for (int k = 0; k < 4; k++) begin
         a = 11'h7FE + AW'(k);
         chk("vb_gnt",  32'(GNT),      32'h4);
         chk("vb_addr", 32'(RAM_ADDR), 32'(a));
         chk("vb_busy", 32'(BUSY),     32'(k != 0));
         tick();
         chk("vb_rvalid", 32'(RVALID), 32'h4);
         chk("vb_rdata",  RDATA,       memval(a));
      end
      chk("vb_data_gnt",  32'(GNT),      32'h1);
      chk("vb_data_busy", 32'(BUSY),     32'h0);
      chk("vb_data_addr", 32'(RAM_ADDR), 32'h030);
      REQ = 3'b000; tick();

      // BLEN above MAX_BURST is clipped to 8 beats
      REQ = 3'b100; BLEN = 4'd15; set_port(2, 11'h100, 1'b0, '0); #1;
      for (int k = 0; k < 8; k++) begin
         chk("cap_gnt",  32'(GNT),      32'h4);
         chk("cap_addr", 32'(RAM_ADDR), 32'(11'h100 + AW'(k)));
         chk("cap_busy", 32'(BUSY),     32'(k != 0));
         tick();
      end
      chk("cap_idle", 32'(BUSY),     32'h0);
      chk("cap_new",  32'(RAM_ADDR), 32'h100);
      tick();
      REQ = 3'b000; #1;
      chk("cap_abort_gnt", 32'(GNT), 32'h0);
      tick();
      chk("cap_end_busy", 32'(BUSY), 32'h0);

      // BLEN = 0 is a single beat with no burst
      REQ = 3'b100; BLEN = 4'd0; set_port(2, 11'h200, 1'b0, '0); #1;
      chk("b0_gnt", 32'(GNT), 32'h4);
      tick();
      REQ = 3'b000; #1;
      chk("b0_busy",   32'(BUSY),   32'h0);
      chk("b0_rvalid", 32'(RVALID), 32'h4);
      chk("b0_rdata",  RDATA,       memval(11'h200));
      tick();

      // Burst abort: fetch wins in the cycle video drops
      REQ = 3'b100; BLEN = 4'd4; set_port(2, 11'h300, 1'b0, '0); #1;
      chk("ab_gnt1", 32'(GNT), 32'h4);
      tick();
      REQ = 3'b110; set_port(1, 11'h040, 1'b0, '0); #1;
      chk("ab_gnt2",  32'(GNT),      32'h4);
      chk("ab_addr2", 32'(RAM_ADDR), 32'h301);
      chk("ab_busy2", 32'(BUSY),     32'h1);
      tick();
      REQ = 3'b010; #1;
      chk("ab_fgnt",  32'(GNT),      32'h2);
      chk("ab_faddr", 32'(RAM_ADDR), 32'h040);
      tick();
      REQ = 3'b000; #1;
      chk("ab_busy",   32'(BUSY),   32'h0);
      chk("ab_rvalid", 32'(RVALID), 32'h2);
      chk("ab_rdata",  RDATA,       memval(11'h040));

      // Write then read-back through a different requester
      REQ = 3'b001; set_port(0, 11'h010, 1'b1, 32'hDEADBEEF); #1;
      chk("wr_gnt",   32'(GNT),    32'h1);
      chk("wr_we",    32'(RAM_WE), 32'h1);
      chk("wr_wdata", RAM_WDATA,   32'hDEADBEEF);
      tick();
      REQ = 3'b010; WE = 3'b000; set_port(1, 11'h010, 1'b0, '0); #1;
      chk("wr_rvalid", 32'(RVALID), 32'h0);
      chk("rd_gnt",    32'(GNT),    32'h2);
      chk("rd_we",     32'(RAM_WE), 32'h0);
      tick();
      REQ = 3'b000; #1;
      chk("rd_rvalid", 32'(RVALID), 32'h2);
      chk("rd_rdata",  RDATA,       32'hDEADBEEF);

      // Reset during beat 2 of a read burst
      REQ = 3'b100; BLEN = 4'd4; set_port(2, 11'h400, 1'b0, '0); #1;
      chk("rb_gnt1", 32'(GNT), 32'h4);
      tick();
      chk("rb_busy",   32'(BUSY),   32'h1);
      chk("rb_rvalid", 32'(RVALID), 32'h4);
      RST = 1'b1; REQ = 3'b111; #1;
      chk("rb_rst_gnt", 32'(GNT),    32'h0);
      chk("rb_rst_en",  32'(RAM_EN), 32'h0);
      tick();
      chk("rb_n_gnt",    32'(GNT),    32'h0);
      chk("rb_n_rvalid", 32'(RVALID), 32'h0);
      chk("rb_n_busy",   32'(BUSY),   32'h0);
      chk("rb_n_we",     32'(RAM_WE), 32'h0);
      set_port(0, 11'h050, 1'b0, '0);
      RST = 1'b0; #1;
      chk("rb_rel_gnt",  32'(GNT),  32'h1);
      chk("rb_rel_busy", 32'(BUSY), 32'h0);
      tick();
      chk("rb_rel_rvalid", 32'(RVALID), 32'h1);
      chk("rb_rel_rdata",  RDATA,       memval(11'h050));
      REQ = 3'b000; tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
